// File: rtl/key_pkg.sv
// ============================================================================
// Module   : key_pkg
// Purpose  : Shared types and helpers for the key conditioner.
//            - key_state_t : per-key debounce FSM states
//            - NUM_KEYS    : number of conditioned push buttons
//            - cnt_width() : counter width for debounce/repeat counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

    localparam int NUM_KEYS = 4;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PEND_PRESS   = 2'd1,
        ST_HELD         = 2'd2,
        ST_PEND_RELEASE = 2'd3
    } key_state_t;

    // Width large enough to hold (max(debounce, repeat, 2) - 1), so the
    // terminal compare is always reached before the counter could wrap.
    function automatic int cnt_width(input int debounce_cycles, input int repeat_cycles);
        int m;
        m = 2;
        if (debounce_cycles > m) m = debounce_cycles;
        if (repeat_cycles > m) m = repeat_cycles;
        return $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_conditioner_if.sv
// ============================================================================
// Module   : key_conditioner_if
// Purpose  : Bundles the key conditioner data signals.
//   key_in      : raw buttons, active-low (0 = pressed)
//   key_level   : debounced state, active-high
//   key_press   : one-cycle press / repeat pulses
//   key_release : one-cycle release pulses
//   master : the side that drives key_in and observes the results
//   slave  : the conditioner side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_conditioner_if;
    import key_pkg::*;

    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release
    );

endinterface

`default_nettype wire

// File: rtl/key_debounce_channel.sv
// ============================================================================
// Module   : key_debounce_channel
// Purpose  : One push button: two-flop synchronizer, debounce FSM,
//            optional auto-repeat counter, registered outputs.
// Ports    :
//   clock       : system clock, rising edge
//   resetn      : asynchronous active-low reset
//   key_raw     : raw button, active-low, asynchronous to clock
//   key_level   : debounced level, active-high
//   key_press   : one-cycle pulse on accepted press and on each repeat tick
//   key_release : one-cycle pulse on accepted release
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int            CW        = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam bit            REPEAT_EN = (REPEAT_CYCLES > 0);

    // ------------------------------------------------------------------
    // Synchronizer: flops reset to 1 (button released), inverted after
    // the second stage so the FSM sees an active-high key.
    // ------------------------------------------------------------------
    logic sync_1;
    logic sync_2;
    logic key_sync;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
        end
    end

    assign key_sync = ~sync_2;

    // ------------------------------------------------------------------
    // Debounce FSM and counters
    // ------------------------------------------------------------------
    key_state_t    state;
    key_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] rcnt_nxt;
    logic          level_q;
    logic          level_nxt;
    logic          press_q;
    logic          press_nxt;
    logic          release_q;
    logic          release_nxt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rcnt      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rcnt      <= rcnt_nxt;
            level_q   <= level_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rcnt_nxt    = rcnt;
        level_nxt   = level_q;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt  = '0;
                rcnt_nxt = '0;
                if (key_sync) begin
                    state_nxt = ST_PEND_PRESS;
                end
            end

            ST_PEND_PRESS: begin
                if (!key_sync) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                    rcnt_nxt  = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_HELD: begin
                if (REPEAT_EN) begin
                    if (rcnt == REP_LAST) begin
                        rcnt_nxt  = '0;
                        press_nxt = 1'b1;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                if (!key_sync) begin
                    state_nxt = ST_PEND_RELEASE;
                    cnt_nxt   = '0;
                end
            end

            ST_PEND_RELEASE: begin
                if (!key_sync && (cnt == DEB_LAST)) begin
                    // Release accepted: the repeat tick is suppressed on this
                    // edge so press and release never coincide.
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    rcnt_nxt    = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    // Repeat keeps running while the release is still pending,
                    // including a bounce back to HELD.
                    if (REPEAT_EN) begin
                        if (rcnt == REP_LAST) begin
                            rcnt_nxt  = '0;
                            press_nxt = 1'b1;
                        end else begin
                            rcnt_nxt = rcnt + 1'b1;
                        end
                    end
                    if (key_sync) begin
                        state_nxt = ST_HELD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                rcnt_nxt  = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
// ============================================================================
// Module   : key_conditioner
// Purpose  : Debounces four independent active-low push buttons and
//            produces a debounced level plus press/release pulses per key.
// Ports    :
//   clock       : system clock, rising edge
//   resetn      : asynchronous active-low reset
//   key_in[3:0] : raw buttons, active-low, asynchronous to clock
//   key_level   : debounced state, active-high (1 = held)
//   key_press   : one-cycle pulse per accepted press / repeat tick
//   key_release : one-cycle pulse per accepted release
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_channel
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_channel (
            .clock       (clock),
            .resetn      (resetn),
            .key_raw     (key_in[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// ============================================================================
// Module   : tb_key_conditioner
// Purpose  : Self-checking bench for key_conditioner. Two instances:
//            A (DEBOUNCE_CYCLES=4, no repeat) and B (DEBOUNCE_CYCLES=4,
//            REPEAT_CYCLES=5). A run-length reference model predicts the
//            outputs every cycle; directed sequences pin latencies literally.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_conditioner;
    import key_pkg::*;

    localparam int D     = 4;
    localparam int REP_A = 0;
    localparam int REP_B = 5;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    key_conditioner_if kif_a ();
    key_conditioner_if kif_b ();

    key_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(REP_A)) dut_a (
        .clock       (clock),
        .resetn      (resetn),
        .key_in      (kif_a.key_in),
        .key_level   (kif_a.key_level),
        .key_press   (kif_a.key_press),
        .key_release (kif_a.key_release)
    );

    key_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(REP_B)) dut_b (
        .clock       (clock),
        .resetn      (resetn),
        .key_in      (kif_b.key_in),
        .key_level   (kif_b.key_level),
        .key_press   (kif_b.key_press),
        .key_release (kif_b.key_release)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] raw_of(input int u);
        return (u == 0) ? kif_a.key_in : kif_b.key_in;
    endfunction

    function automatic logic [3:0] level_of(input int u);
        return (u == 0) ? kif_a.key_level : kif_b.key_level;
    endfunction

    function automatic logic [3:0] press_of(input int u);
        return (u == 0) ? kif_a.key_press : kif_b.key_press;
    endfunction

    function automatic logic [3:0] rel_of(input int u);
        return (u == 0) ? kif_a.key_release : kif_b.key_release;
    endfunction

    // ------------------------------------------------------------------
    // Reference model. The key seen by the debouncer is the raw value
    // delayed by two clock samples and inverted. A change is accepted once
    // D+1 consecutive samples disagree with the current level. Repeat ticks
    // fire every R edges after acceptance while the level stays high, except
    // on the edge that accepts the release.
    // ------------------------------------------------------------------
    logic [3:0] m_h1 [2];
    logic [3:0] m_h2 [2];
    logic [3:0] exp_level [2];
    logic [3:0] exp_press [2];
    logic [3:0] exp_rel [2];
    int         m_run [2][4];
    int         m_k [2][4];

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_h1[u] = 4'hF;
            m_h2[u] = 4'hF;
            exp_level[u] = 4'h0;
            exp_press[u] = 4'h0;
            exp_rel[u]   = 4'h0;
            for (int b = 0; b < 4; b++) begin
                m_run[u][b] = 0;
                m_k[u][b]   = 0;
            end
        end
    endtask

    task automatic model_step();
        logic [3:0] raw;
        logic       s;
        int         rep;
        for (int u = 0; u < 2; u++) begin
            raw = raw_of(u);
            rep = (u == 0) ? REP_A : REP_B;
            exp_press[u] = 4'h0;
            exp_rel[u]   = 4'h0;
            for (int b = 0; b < 4; b++) begin
                s = ~m_h2[u][b];
                m_h2[u][b] = m_h1[u][b];
                m_h1[u][b] = raw[b];
                if (s != exp_level[u][b]) m_run[u][b]++;
                else m_run[u][b] = 0;
                if (m_run[u][b] == D + 1) begin
                    exp_level[u][b] = s;
                    m_run[u][b] = 0;
                    if (s) begin
                        exp_press[u][b] = 1'b1;
                        m_k[u][b] = 0;
                    end else begin
                        exp_rel[u][b] = 1'b1;
                    end
                end else if (exp_level[u][b] && rep > 0) begin
                    m_k[u][b]++;
                    if (m_k[u][b] % rep == 0) exp_press[u][b] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge resetn);
            if (!resetn) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            check4("level_a",   kif_a.key_level,   exp_level[0]);
            check4("press_a",   kif_a.key_press,   exp_press[0]);
            check4("release_a", kif_a.key_release, exp_rel[0]);
            check4("level_b",   kif_b.key_level,   exp_level[1]);
            check4("press_b",   kif_b.key_press,   exp_press[1]);
            check4("release_b", kif_b.key_release, exp_rel[1]);
            check4("overlap_a", kif_a.key_press & kif_a.key_release, 4'h0);
            check4("overlap_b", kif_b.key_press & kif_b.key_release, 4'h0);
        end
    end

    // Counts edges (first edge after the call = 1) until key b of instance
    // u reaches the wanted level; -1 when the budget runs out.
    task automatic wait_level(input int u, input int b, input logic want, output int n);
        logic [3:0] lv;
        n = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clock);
            #1;
            lv = level_of(u);
            if (lv[b] == want) begin
                n = e;
                return;
            end
        end
    endtask

    int         n;
    int         rate;
    int         rep_cnt;
    int         rep_first;
    logic [3:0] acc;
    logic [3:0] pv;

    initial begin
        resetn       = 1'b0;
        kif_a.key_in = 4'hF;
        kif_b.key_in = 4'hF;
        repeat (3) @(posedge clock);
        #1;
        check4("reset_level_a", kif_a.key_level, 4'h0);
        check4("reset_press_b", kif_b.key_press, 4'h0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (4) @(negedge clock);

        // Single press on key 3: accepted 6 edges after the sampling edge.
        kif_a.key_in[3] = 1'b0;
        wait_level(0, 3, 1'b1, n);
        check_int("press_latency_k3", n, 7);
        check4("press_pulse_k3", kif_a.key_press, 4'b1000);
        check4("level_only_k3", kif_a.key_level, 4'b1000);
        @(posedge clock);
        #1;
        check4("press_one_cycle_k3", kif_a.key_press, 4'b0000);
        @(negedge clock);
        kif_a.key_in[3] = 1'b1;
        wait_level(0, 3, 1'b0, n);
        check_int("release_latency_k3", n, 7);
        check4("release_pulse_k3", kif_a.key_release, 4'b1000);
        repeat (5) @(negedge clock);

        // Glitch of 3 cycles on key 2: nothing may move.
        kif_a.key_in[2] = 1'b0;
        repeat (3) @(negedge clock);
        kif_a.key_in[2] = 1'b1;
        acc = 4'h0;
        repeat (20) begin
            @(posedge clock);
            #1;
            acc = acc | kif_a.key_level | kif_a.key_press | kif_a.key_release;
        end
        check4("glitch_no_change", acc, 4'h0);

        // Key 0 held 20 cycles then released.
        @(negedge clock);
        kif_a.key_in[0] = 1'b0;
        wait_level(0, 0, 1'b1, n);
        check_int("press_latency_k0", n, 7);
        repeat (20) @(negedge clock);
        kif_a.key_in[0] = 1'b1;
        wait_level(0, 0, 1'b0, n);
        check_int("release_latency_k0", n, 7);
        check4("release_pulse_k0", kif_a.key_release, 4'b0001);
        check4("no_press_at_release_k0", kif_a.key_press, 4'b0000);
        repeat (5) @(negedge clock);

        // Auto-repeat on instance B, key 1.
        kif_b.key_in[1] = 1'b0;
        wait_level(1, 1, 1'b1, n);
        check_int("repeat_accept_latency", n, 7);
        check4("repeat_first_press", kif_b.key_press, 4'b0010);
        rep_cnt   = 0;
        rep_first = -1;
        for (int j = 1; j <= 28; j++) begin
            @(posedge clock);
            #1;
            pv = kif_b.key_press;
            if (pv[1]) begin
                rep_cnt++;
                if (rep_first < 0) rep_first = j;
            end
        end
        check_int("repeat_count_28", rep_cnt, 5);
        check_int("repeat_first_offset", rep_first, 5);
        @(negedge clock);
        kif_b.key_in[1] = 1'b1;
        repeat (15) @(negedge clock);

        // All four keys pressed on the same edge.
        kif_a.key_in = 4'h0;
        wait_level(0, 0, 1'b1, n);
        check_int("all_keys_latency", n, 7);
        check4("all_keys_press", kif_a.key_press, 4'hF);
        @(negedge clock);
        kif_a.key_in = 4'hF;
        repeat (15) @(negedge clock);

        // Reset mid-hold (key 2) and mid-debounce (key 0).
        kif_a.key_in[2] = 1'b0;
        wait_level(0, 2, 1'b1, n);
        check_int("hold_before_reset", n, 7);
        @(negedge clock);
        kif_a.key_in[0] = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check4("reset_async_level", kif_a.key_level, 4'h0);
        check4("reset_async_press", kif_a.key_press, 4'h0);
        check4("reset_async_rel",   kif_a.key_release, 4'h0);
        @(negedge clock);
        resetn = 1'b1;
        wait_level(0, 0, 1'b1, n);
        check_int("post_reset_latency", n, 7);
        check4("post_reset_level", kif_a.key_level, 4'b0101);
        check4("post_reset_no_rel", kif_a.key_release, 4'b0000);
        @(negedge clock);
        kif_a.key_in = 4'hF;
        repeat (15) @(negedge clock);

        // Randomized bouncing with varying toggle rates and sparse resets.
        rate = 6;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            if (cyc % 64 == 0) rate = $urandom_range(2, 14);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, rate - 1) == 0) kif_a.key_in[b] = ~kif_a.key_in[b];
                if ($urandom_range(0, rate - 1) == 0) kif_b.key_in[b] = ~kif_b.key_in[b];
            end
            if ($urandom_range(0, 799) == 0) begin
                #2;
                resetn = 1'b0;
                #2;
                resetn = 1'b1;
            end
        end
        repeat (20) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable synchronized samples before a key change is accepted (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 0, auto-repeat period for key_press while a key is held; 0 disables repeat.
REQ-003 SHALL have port clock  input  1  single system clock; all flops on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key_in  input  4  raw push buttons, active-low (0 = pressed), asynchronous to clock.
REQ-006 SHALL have port key_level  output  4  debounced key state, active-high (1 = held); feeds the draw stage key input.
REQ-007 SHALL have port key_press  output  4  one-cycle pulse per accepted press (and per repeat tick).
REQ-008 SHALL have port key_release  output  4  one-cycle pulse per accepted release.

Function
REQ-009 SHALL pass each key_in bit through a two-flop synchronizer, inverted to active-high after the second flop.
REQ-010 SHALL process the four keys independently; no key affects another key's state or counters.
REQ-011 SHALL implement per key an FSM with states IDLE, PEND_PRESS, HELD, PEND_RELEASE.
REQ-012 IDLE -> PEND_PRESS when synchronized key = 1; counter cleared.
REQ-013 PEND_PRESS: counter increments each cycle the synchronized key = 1; return to IDLE with counter cleared the first cycle it = 0.
REQ-014 PEND_PRESS -> HELD on the cycle the counter equals DEBOUNCE_CYCLES-1 with key still 1; key_level rises and key_press pulses on that same registered edge.
REQ-015 HELD -> PEND_RELEASE when synchronized key = 0; PEND_RELEASE mirrors REQ-013/014 with polarity swapped, ending in IDLE with key_level falling and key_release pulsing.
REQ-016 Latency: a clean raw edge SHALL appear on key_level exactly 2 + DEBOUNCE_CYCLES clock edges after the first clock edge sampling the new raw value.
REQ-017 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on any output.
REQ-018 With REPEAT_CYCLES > 0, a repeat counter SHALL start at 0 on entry to HELD and pulse key_press each time it reaches REPEAT_CYCLES-1, then wrap to 0; it SHALL keep counting in PEND_RELEASE and be cleared on entry to IDLE.
REQ-019 key_press and key_release for one key SHALL never be high in the same cycle; each pulse SHALL last exactly one cycle.
REQ-020 Counters SHALL saturate-free: width = clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES, 2)); no wrap occurs before the terminal compare.
REQ-021 All outputs SHALL be registered; no combinational path from key_in to any output.

Reset
REQ-022 On resetn = 0, synchronizer flops SHALL load 1 (released), FSMs IDLE, all counters 0, key_level/key_press/key_release 4'b0000, immediately and asynchronously.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL discard the pending change and emit no release pulse.
REQ-024 After resetn deasserts with a key already held, that key SHALL be accepted as a normal press after 2 + DEBOUNCE_CYCLES cycles.

Structure
REQ-025 FSM state enum and counter-width function SHALL live in shared package key_pkg.
REQ-026 Per-key logic (synchronizer, FSM, counters) SHALL be sub-module key_debounce_channel, instantiated four times by key_conditioner.

Verification (DEBOUNCE_CYCLES = 4, REPEAT_CYCLES = 0 unless noted)
REQ-027 key_in[3] 1->0 held -> key_level[3] = 1 and key_press[3] pulse exactly 6 edges later; other bits stay 0.
REQ-028 key_in[2] low for 3 cycles then high -> no output change on any bit.
REQ-029 key_in[0] press then release after 20 cycles -> key_release[0] pulse 6 edges after release; key_press/key_release never coincide.
REQ-030 REPEAT_CYCLES = 5, key_in[1] held 30 cycles -> key_press[1] at acceptance, then every 5 cycles while held.
REQ-031 resetn pulsed low at cycle 3 of a pending press -> all outputs 0 at once; press accepted 6 edges after resetn rises.
REQ-032 All four keys pressed on the same edge -> all key_press bits pulse on the same cycle.
